regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of write-back requesters (2..8).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  NUM_SRC  per-source write request valid.
REQ-005 SHALL have port req_ready  output  NUM_SRC  per-source accept.
REQ-006 SHALL have port req_sel  input  4*NUM_SRC  per-source destination register (source i at bits 4i+3:4i).
REQ-007 SHALL have port req_width  input  2*NUM_SRC  per-source width code (0=8b, 1=16b, 2=32b, 3=64b).
REQ-008 SHALL have port req_data  input  64*NUM_SRC  per-source write data.
REQ-009 SHALL have port rf_wr  output  1  register-file write strobe.
REQ-010 SHALL have port rf_wrsel  output  4  register-file write select.
REQ-011 SHALL have port rf_width  output  2  register-file width code.
REQ-012 SHALL have port rf_din  output  64  register-file write data.
REQ-013 SHALL have, under the REQ-027 macro only, ports alloc_valid input 1, alloc_sel input 4, and busy output 16 (per-register pending-write bit).

Function
REQ-014 SHALL hold one single-entry buffer per source (sel, width, data, full flag).
REQ-015 SHALL capture the source's request into its buffer on the clock edge where req_valid[i] and req_ready[i] are both high.
REQ-016 SHALL drive req_ready[i] = ~full[i] | grant[i], so each source sustains one request per cycle.
REQ-017 SHALL grant at most one full buffer per cycle, round-robin: search starts at the source after the last granted source; the pointer advances only on a grant.
REQ-018 SHALL register the granted entry onto rf_wr/rf_wrsel/rf_width/rf_din; rf_wr is high for exactly one cycle per grant.
REQ-019 SHALL give latency of 2 cycles: handshake in cycle N -> rf_wr high in cycle N+2 when uncontended.
REQ-020 SHALL mask rf_din to the width code (upper bits zero) before output.
REQ-021 SHALL hold rf_wrsel/rf_width/rf_din at their last values when rf_wr is low.
REQ-022 SHALL write same-register requests from different sources in grant order without merging or dropping any.
REQ-023 SHALL let a buffer that is granted and refilled in the same cycle stay full with the new entry.

Reset
REQ-024 SHALL, on reset, clear all buffer full flags, rf_wr=0, rf_wrsel=0, rf_width=0, rf_din=0, pointer=0, busy=0.
REQ-025 SHALL, on reset mid-operation, discard buffered and in-flight writes with no rf_wr pulse in the reset cycle or the cycle after.
REQ-026 SHALL drive req_ready all-zero while reset is high.

Configuration
REQ-027 SHALL, with macro REGFILE_SCOREBOARD_EN defined, set busy[alloc_sel] on alloc_valid and clear busy[rf_wrsel] in the cycle after rf_wr is high.
REQ-028 SHALL, for simultaneous set and clear of the same register, let set win.
REQ-029 SHALL, without REGFILE_SCOREBOARD_EN, omit the alloc_valid/alloc_sel/busy ports and all scoreboard state.

Structure
REQ-030 SHALL place the width-code typedef (W8/W16/W32/W64), REG_W=64, NREG=16 and the request struct (sel, width, data) in shared package rf_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arbiter (NUM_SRC request in, one-hot grant out, pointer update on grant).

Verification
REQ-032 SHALL test single-source write: source 0 sel=5, width=3, data=64'h1122334455667788 at cycle 1 -> rf_wr in cycle 3 with rf_wrsel=5, rf_din=64'h1122334455667788.
REQ-033 SHALL test width masking: width=0, data=64'hFFFF_FFFF_FFFF_FFAB -> rf_din=64'hAB, rf_width=0.
REQ-034 SHALL test contention: all 3 sources valid every cycle for 9 cycles -> grants 0,1,2,0,1,2..., one rf_wr per cycle, no request lost, and req_ready never all-high while all buffers are full and ungranted.
REQ-035 SHALL test reset mid-operation: 3 buffers full, reset asserted 1 cycle -> no rf_wr for 2 cycles, req_ready=0 during reset, and no stale write after reset.
REQ-036 SHALL test the scoreboard (REGFILE_SCOREBOARD_EN): alloc sel=7, then source 1 writes reg 7 -> busy[7]=1 until the cycle after rf_wr; simultaneous alloc of 7 and write-back of 7 -> busy[7] stays 1.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back path: width codes, request
// record and the width mask applied to outgoing write data.
package rf_pkg;

  localparam int REG_W = 64;
  localparam int NREG  = 16;

  typedef enum logic [1:0] {
    W8  = 2'd0,
    W16 = 2'd1,
    W32 = 2'd2,
    W64 = 2'd3
  } width_t;

  typedef struct packed {
    logic [3:0]       sel;
    width_t           width;
    logic [REG_W-1:0] data;
  } rf_req_t;

  function automatic logic [REG_W-1:0] mask_data(width_t w, logic [REG_W-1:0] d);
    logic [REG_W-1:0] m;
    m = d;
    case (w)
      W8:      m = {56'd0, d[7:0]};
      W16:     m = {48'd0, d[15:0]};
      W32:     m = {32'd0, d[31:0]};
      default: m = d;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at ptr_reg, which holds
// the index after the last granted source and only moves on a grant.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  always_comb begin
    logic found;
    int   pos;
    found    = 1'b0;
    pos      = 0;
    grant    = '0;
    ptr_next = ptr_reg;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr_reg) + k;
      if (pos >= N) pos = pos - N;
      for (int i = 0; i < N; i++) begin
        if (!found && pos == i && req[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          ptr_next = (i == N - 1) ? '0 : PW'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: one buffer per source, round-robin drain
// onto a registered write port. REGFILE_SCOREBOARD_EN adds a busy scoreboard.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_SRC = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    req_valid,
  output logic [NUM_SRC-1:0]    req_ready,
  input  logic [4*NUM_SRC-1:0]  req_sel,
  input  logic [2*NUM_SRC-1:0]  req_width,
  input  logic [64*NUM_SRC-1:0] req_data,
  output logic                  rf_wr,
  output logic [3:0]            rf_wrsel,
  output logic [1:0]            rf_width,
  output logic [63:0]           rf_din
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                  alloc_valid,
  input  logic [3:0]            alloc_sel,
  output logic [15:0]           busy
`endif
);

  logic [NUM_SRC-1:0] full;
  logic [NUM_SRC-1:0] grant;
  rf_req_t            buf_entry [NUM_SRC];
  rf_req_t            gnt_entry;

  logic               rf_wr_reg;
  logic [3:0]         rf_wrsel_reg;
  logic [1:0]         rf_width_reg;
  logic [REG_W-1:0]   rf_din_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic    full_reg;
      rf_req_t entry_reg;

      // A grant and a refill in the same cycle leave the buffer full with the new entry.
      always_ff @(posedge clk) begin
        if (reset) begin
          full_reg  <= 1'b0;
          entry_reg <= '0;
        end else if (req_valid[gi] && req_ready[gi]) begin
          full_reg  <= 1'b1;
          entry_reg <= '{sel:   req_sel[4*gi +: 4],
                         width: width_t'(req_width[2*gi +: 2]),
                         data:  req_data[64*gi +: 64]};
        end else if (grant[gi]) begin
          full_reg  <= 1'b0;
        end
      end

      assign full[gi]      = full_reg;
      assign buf_entry[gi] = entry_reg;
      assign req_ready[gi] = ~reset & (~full_reg | grant[gi]);
    end
  endgenerate

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (full & {NUM_SRC{~reset}}),
    .grant (grant)
  );

  always_comb begin
    gnt_entry = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant[i]) gnt_entry = buf_entry[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wr_reg    <= 1'b0;
      rf_wrsel_reg <= '0;
      rf_width_reg <= '0;
      rf_din_reg   <= '0;
    end else if (|grant) begin
      rf_wr_reg    <= 1'b1;
      rf_wrsel_reg <= gnt_entry.sel;
      rf_width_reg <= gnt_entry.width;
      rf_din_reg   <= mask_data(gnt_entry.width, gnt_entry.data);
    end else begin
      rf_wr_reg    <= 1'b0;
    end
  end

  // The strobe is suppressed while reset is high so an in-flight write never lands.
  assign rf_wr    = rf_wr_reg & ~reset;
  assign rf_wrsel = rf_wrsel_reg;
  assign rf_width = rf_width_reg;
  assign rf_din   = rf_din_reg;

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Clear is applied before set so a same-cycle alloc of the register wins.
  always_comb begin
    busy_next = busy_reg;
    if (rf_wr)       busy_next[rf_wrsel] = 1'b0;
    if (alloc_valid) busy_next[alloc_sel] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy_reg <= '0;
    else       busy_reg <= busy_next;
  end

  assign busy = busy_reg;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter; scoreboard tests run when
// REGFILE_SCOREBOARD_EN is defined.
module tb_regfile_wb_arbiter;

  localparam int NS = 3;

  typedef struct packed {
    logic [3:0]  sel;
    logic [1:0]  width;
    logic [63:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NS-1:0]    req_valid = '0;
  logic [NS-1:0]    req_ready;
  logic [4*NS-1:0]  req_sel = '0;
  logic [2*NS-1:0]  req_width = '0;
  logic [64*NS-1:0] req_data = '0;
  logic             rf_wr;
  logic [3:0]       rf_wrsel;
  logic [1:0]       rf_width;
  logic [63:0]      rf_din;
`ifdef REGFILE_SCOREBOARD_EN
  logic             alloc_valid = 1'b0;
  logic [3:0]       alloc_sel = '0;
  logic [15:0]      busy;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  regfile_wb_arbiter #(.NUM_SRC(NS)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_sel   (req_sel),
    .req_width (req_width),
    .req_data  (req_data),
    .rf_wr     (rf_wr),
    .rf_wrsel  (rf_wrsel),
    .rf_width  (rf_width),
    .rf_din    (rf_din)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .alloc_valid (alloc_valid),
    .alloc_sel   (alloc_sel),
    .busy        (busy)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_wr === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got sel=%0d width=%0d din=%h, expected no write",
                 rf_wrsel, rf_width, rf_din);
      end else begin
        mon_e = exp_q.pop_front();
        if (rf_wrsel !== mon_e.sel || rf_width !== mon_e.width || rf_din !== mon_e.data) begin
          errors++;
          $display("FAIL write_data got sel=%0d width=%0d din=%h, expected sel=%0d width=%0d din=%h",
                   rf_wrsel, rf_width, rf_din, mon_e.sel, mon_e.width, mon_e.data);
        end else begin
          $display("write sel=%0d width=%0d din=%h", rf_wrsel, rf_width, rf_din);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int s, input logic v, input logic [3:0] sel,
                       input logic [1:0] w, input logic [63:0] d);
    req_valid[s]         = v;
    req_sel[4*s +: 4]    = sel;
    req_width[2*s +: 2]  = w;
    req_data[64*s +: 64] = d;
  endtask

  function automatic exp_t item(int s, int k);
    exp_t e;
    e.sel   = 4'(s * 4 + k);
    e.width = 2'd3;
    e.data  = {8'(s), 24'hC0FFEE, 24'h0, 8'(k)};
    return e;
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b000) begin
      errors++; $display("FAIL reset_ready got %b expected 000", req_ready);
    end
    checks++;
    if (rf_wr !== 1'b0) begin
      errors++; $display("FAIL reset_wr got %b expected 0", rf_wr);
    end
    tick();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (rf_wrsel !== 4'd0 || rf_width !== 2'd0 || rf_din !== 64'd0) begin
      errors++; $display("FAIL reset_outputs got sel=%0d width=%0d din=%h expected zeros",
                         rf_wrsel, rf_width, rf_din);
    end
    checks++;
    if (req_ready !== 3'b111) begin
      errors++; $display("FAIL post_reset_ready got %b expected 111", req_ready);
    end
`ifdef REGFILE_SCOREBOARD_EN
    checks++;
    if (busy !== 16'd0) begin
      errors++; $display("FAIL reset_busy got %h expected 0000", busy);
    end
`endif
    tick();
  endtask

  task automatic test_single();
    drive(0, 1'b1, 4'd5, 2'd3, 64'h1122334455667788);
    exp_q.push_back('{sel: 4'd5, width: 2'd3, data: 64'h1122334455667788});
    @(negedge clk);
    checks++;
    if (req_ready[0] !== 1'b1) begin
      errors++; $display("FAIL single_ready got %b expected 1", req_ready[0]);
    end
    tick();
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b0) begin
      errors++; $display("FAIL single_early got rf_wr=%b expected 0", rf_wr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b1 || rf_wrsel !== 4'd5 || rf_din !== 64'h1122334455667788) begin
      errors++; $display("FAIL single_write got wr=%b sel=%0d din=%h expected wr=1 sel=5 din=1122334455667788",
                         rf_wr, rf_wrsel, rf_din);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b0 || rf_wrsel !== 4'd5 || rf_din !== 64'h1122334455667788) begin
      errors++; $display("FAIL single_hold got wr=%b sel=%0d din=%h expected wr=0 sel=5 din=1122334455667788",
                         rf_wr, rf_wrsel, rf_din);
    end
    tick();
  endtask

  task automatic test_width_mask();
    drive(0, 1'b1, 4'd9, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB);
    exp_q.push_back('{sel: 4'd9, width: 2'd0, data: 64'h0000_0000_0000_00AB});
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b1 || rf_din !== 64'hAB || rf_width !== 2'd0) begin
      errors++; $display("FAIL width8 got wr=%b din=%h width=%0d expected wr=1 din=ab width=0",
                         rf_wr, rf_din, rf_width);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 2; k++) begin
      drive(2, 1'b1, 4'(10 + k), 2'(k + 1), 64'hFEDC_BA98_7654_3210);
      @(negedge clk);
      checks++;
      if (req_ready[2] !== 1'b1) begin
        errors++; $display("FAIL b2b_ready%0d got %b expected 1", k, req_ready[2]);
      end
      tick();
    end
    exp_q.push_back('{sel: 4'd10, width: 2'd1, data: 64'h0000_0000_0000_3210});
    exp_q.push_back('{sel: 4'd11, width: 2'd2, data: 64'h0000_0000_7654_3210});
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b1 || rf_din !== 64'h3210 || rf_width !== 2'd1) begin
      errors++; $display("FAIL b2b_w16 got wr=%b din=%h width=%0d expected wr=1 din=3210 width=1",
                         rf_wr, rf_din, rf_width);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b1 || rf_din !== 64'h7654_3210 || rf_width !== 2'd2) begin
      errors++; $display("FAIL b2b_w32 got wr=%b din=%h width=%0d expected wr=1 din=76543210 width=2",
                         rf_wr, rf_din, rf_width);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got wr=%b expected 0", rf_wr);
    end
    tick();
  endtask

  task automatic test_contention();
    int         cnt[3];
    logic [2:0] exp_rdy;
    exp_t       e;
    do_reset();
    cnt = '{0, 0, 0};
    // Round-robin from source 0: write j comes from source j%3, its (j/3)-th request.
    for (int j = 0; j < 11; j++) exp_q.push_back(item(j % 3, j / 3));
    for (int t = 0; t < 13; t++) begin
      for (int s = 0; s < 3; s++) begin
        e = item(s, cnt[s]);
        drive(s, t < 9, e.sel, e.width, e.data);
      end
      @(negedge clk);
      if (t < 9) begin
        exp_rdy = (t == 0) ? 3'b111 : 3'(3'b001 << ((t - 1) % 3));
        checks++;
        if (req_ready !== exp_rdy) begin
          errors++; $display("FAIL contention_ready cycle %0d got %b expected %b", t, req_ready, exp_rdy);
        end
        for (int s = 0; s < 3; s++) if (req_ready[s]) cnt[s]++;
      end
      if (t >= 2) begin
        checks++;
        if (rf_wr !== 1'b1) begin
          errors++; $display("FAIL contention_wr cycle %0d got %b expected 1", t, rf_wr);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (rf_wr !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL contention_drain got wr=%b pending=%0d expected wr=0 pending=0",
                         rf_wr, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 3; s++) drive(s, 1'b1, 4'(s + 1), 2'd3, 64'hBAD0_0000_0000_0000 | 64'(s));
      tick();
    end
    reset     = 1'b1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (req_ready !== 3'b000 || rf_wr !== 1'b0) begin
      errors++; $display("FAIL midreset_cycle got ready=%b wr=%b expected ready=000 wr=0", req_ready, rf_wr);
    end
    tick();
    reset = 1'b0;
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      checks++;
      if (rf_wr !== 1'b0 || rf_din !== 64'd0) begin
        errors++; $display("FAIL midreset_stale cycle %0d got wr=%b din=%h expected wr=0 din=0", t, rf_wr, rf_din);
      end
      tick();
    end
  endtask

`ifdef REGFILE_SCOREBOARD_EN
  task automatic test_scoreboard();
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      alloc_valid = 1'b1;
      alloc_sel   = 4'd7;
      tick();
      alloc_valid = 1'b0;
      drive(1, 1'b1, 4'd7, 2'd3, 64'h5C0B_0000_0000_0000 | 64'(pass));
      exp_q.push_back('{sel: 4'd7, width: 2'd3, data: 64'h5C0B_0000_0000_0000 | 64'(pass)});
      @(negedge clk);
      checks++;
      if (busy[7] !== 1'b1) begin
        errors++; $display("FAIL sb_set pass %0d got %b expected 1", pass, busy[7]);
      end
      tick();
      req_valid = '0;
      tick();
      alloc_valid = (pass == 1);
      @(negedge clk);
      checks++;
      if (rf_wr !== 1'b1 || busy[7] !== 1'b1) begin
        errors++; $display("FAIL sb_wr pass %0d got wr=%b busy=%b expected wr=1 busy=1", pass, rf_wr, busy[7]);
      end
      tick();
      alloc_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (busy[7] !== 1'(pass)) begin
        errors++; $display("FAIL sb_after pass %0d got %b expected %0d", pass, busy[7], pass);
      end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_width_mask();
    test_back_to_back();
    test_contention();
    test_reset_mid();
`ifdef REGFILE_SCOREBOARD_EN
    test_scoreboard();
`endif
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL final_queue got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
